// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: packed BCD time layout, button codes
// and the alarm scheduler state encoding.
package clock_pkg;

  localparam int unsigned TIME_W    = 20;

  localparam int unsigned SEC_L_LSB = 0;
  localparam int unsigned SEC_L_W   = 4;
  localparam int unsigned SEC_H_LSB = 4;
  localparam int unsigned SEC_H_W   = 3;
  localparam int unsigned MIN_L_LSB = 7;
  localparam int unsigned MIN_L_W   = 4;
  localparam int unsigned MIN_H_LSB = 11;
  localparam int unsigned MIN_H_W   = 3;
  localparam int unsigned HOU_L_LSB = 14;
  localparam int unsigned HOU_L_W   = 4;
  localparam int unsigned HOU_H_LSB = 18;
  localparam int unsigned HOU_H_W   = 2;

  typedef enum logic [2:0] {
    BtnMid,
    BtnUp,
    BtnLeft,
    BtnRight,
    BtnDown
  } btn_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StRing,
    StSnooze
  } alarm_state_e;

endpackage

// File: rtl/bcd_time_add.sv
// Adds 1..9 minutes to a packed BCD time of day; seconds pass through unchanged,
// hours wrap at 24.
module bcd_time_add
  import clock_pkg::*;
(
  input  logic [TIME_W-1:0] cur_time,
  input  logic [3:0]        add_min,
  output logic [TIME_W-1:0] sum_time
);

  logic [MIN_L_W-1:0] min_l, new_min_l;
  logic [MIN_H_W-1:0] min_h, new_min_h;
  logic [HOU_L_W-1:0] hou_l, new_hou_l;
  logic [HOU_H_W-1:0] hou_h, new_hou_h;
  logic [4:0]         min_l_sum;
  logic               c_min, c_hour;

  assign min_l = cur_time[MIN_L_LSB +: MIN_L_W];
  assign min_h = cur_time[MIN_H_LSB +: MIN_H_W];
  assign hou_l = cur_time[HOU_L_LSB +: HOU_L_W];
  assign hou_h = cur_time[HOU_H_LSB +: HOU_H_W];

  always_comb begin
    min_l_sum = 5'(min_l) + 5'(add_min);
    c_min     = (min_l_sum > 5'd9);
    new_min_l = c_min ? 4'(min_l_sum - 5'd10) : min_l_sum[3:0];

    new_min_h = min_h;
    c_hour    = 1'b0;
    if (c_min) begin
      if (min_h == 3'd5) begin
        new_min_h = '0;
        c_hour    = 1'b1;
      end else begin
        new_min_h = min_h + 3'd1;
      end
    end

    new_hou_l = hou_l;
    new_hou_h = hou_h;
    if (c_hour) begin
      if (hou_h == 2'd2 && hou_l == 4'd3) begin
        new_hou_l = '0;
        new_hou_h = '0;
      end else if (hou_l == 4'd9) begin
        new_hou_l = '0;
        new_hou_h = hou_h + 2'd1;
      end else begin
        new_hou_l = hou_l + 4'd1;
      end
    end

    sum_time = {new_hou_h, new_hou_l, new_min_h, new_min_l,
                cur_time[SEC_H_LSB +: SEC_H_W], cur_time[SEC_L_LSB +: SEC_L_W]};
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: scans slots one per cycle on each second tick and
// sequences ring / snooze / dismiss.
module alarm_scheduler
  import clock_pkg::*;
#(
  parameter int unsigned N_ALARM      = 4,
  parameter int unsigned SLOT_W       = 2,
  parameter int unsigned RING_SECONDS = 60,
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sec_tick,
  input  logic [TIME_W-1:0]   now_time,
  input  logic                cfg_we,
  input  logic [SLOT_W-1:0]   cfg_slot,
  input  logic [TIME_W-1:0]   cfg_time,
  input  logic                cfg_en,
  input  logic                ack,
  input  logic                snooze,
  output logic                ringing,
  output logic [SLOT_W-1:0]   ring_slot,
  output logic                snoozed,
  output logic [N_ALARM-1:0]  armed
);

  logic [TIME_W-1:0]  slot_time_q [N_ALARM];
  logic [N_ALARM-1:0] slot_en_q;

  alarm_state_e      state_q, state_d;
  logic [SLOT_W-1:0] scan_idx_q, scan_idx_d;
  logic [SLOT_W-1:0] ring_slot_q, ring_slot_d;
  logic [7:0]        ring_cnt_q, ring_cnt_d;
  logic [7:0]        snooze_cnt_q, snooze_cnt_d;
  logic [TIME_W-1:0] snooze_time_q, snooze_time_d, snooze_target;
  logic              snz_pend_q, snz_pend_d;
  logic              slot_hit, scan_last, ring_kill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_ALARM; i++) slot_time_q[i] <= '0;
      slot_en_q <= '0;
    end else if (cfg_we) begin
      slot_time_q[cfg_slot] <= cfg_time;
      slot_en_q[cfg_slot]   <= cfg_en;
    end
  end

  bcd_time_add u_snooze_add (
    .cur_time (now_time),
    .add_min  (4'(SNOOZE_MIN)),
    .sum_time (snooze_target)
  );

  assign slot_hit  = slot_en_q[scan_idx_q] && (slot_time_q[scan_idx_q] == now_time);
  assign scan_last = (scan_idx_q == SLOT_W'(N_ALARM - 1));
  // Disabling the slot that owns the current ring/snooze abandons it.
  assign ring_kill = cfg_we && !cfg_en && (cfg_slot == ring_slot_q) &&
                     (state_q == StRing || state_q == StSnooze);

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    ring_slot_d   = ring_slot_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    snooze_time_d = snooze_time_q;
    snz_pend_d    = snz_pend_q;

    unique case (state_q)
      StIdle: begin
        if (sec_tick) begin
          state_d    = StScan;
          scan_idx_d = '0;
        end
      end
      StScan: begin
        if (slot_hit) begin
          state_d       = StRing;
          ring_slot_d   = scan_idx_q;
          ring_cnt_d    = 8'(RING_SECONDS);
          snooze_cnt_d  = '0;
          snooze_time_d = '0;
          snz_pend_d    = 1'b0;
        end else if (scan_last) begin
          state_d = snz_pend_q ? StSnooze : StIdle;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      StRing: begin
        if (ring_kill || ack) begin
          state_d = StIdle;
        end else if (snooze) begin
          if (snooze_cnt_q < 8'(MAX_SNOOZE)) begin
            state_d       = StSnooze;
            snooze_time_d = snooze_target;
            snooze_cnt_d  = snooze_cnt_q + 8'd1;
            snz_pend_d    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (sec_tick) begin
          ring_cnt_d = ring_cnt_q - 8'd1;
          if (ring_cnt_q <= 8'd1) state_d = StIdle;
        end
      end
      StSnooze: begin
        if (ring_kill || ack) begin
          state_d    = StIdle;
          snz_pend_d = 1'b0;
        end else if (sec_tick) begin
          if (now_time == snooze_time_q) begin
            state_d    = StRing;
            ring_cnt_d = 8'(RING_SECONDS);
            snz_pend_d = 1'b0;
          end else begin
            state_d    = StScan;
            scan_idx_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      scan_idx_q    <= '0;
      ring_slot_q   <= '0;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= '0;
      snooze_time_q <= '0;
      snz_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      ring_slot_q   <= ring_slot_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_cnt_q  <= snooze_cnt_d;
      snooze_time_q <= snooze_time_d;
      snz_pend_q    <= snz_pend_d;
    end
  end

  assign ringing   = (state_q == StRing);
  assign snoozed   = (state_q == StSnooze) || (state_q == StScan && snz_pend_q);
  assign ring_slot = ring_slot_q;
  assign armed     = slot_en_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: expectations are queued as stimulus is
// driven and popped against the DUT outputs when they are due.
module tb_alarm_scheduler;

  localparam int unsigned N_ALARM = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned SPACING = 7;

  localparam int T0730 = 7 * 3600 + 30 * 60;
  localparam int T1200 = 12 * 3600;
  localparam int T2358 = 23 * 3600 + 58 * 60;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               sec_tick = 1'b0;
  logic [19:0]        now_time = '0;
  logic               cfg_we = 1'b0;
  logic [SLOT_W-1:0]  cfg_slot = '0;
  logic [19:0]        cfg_time = '0;
  logic               cfg_en = 1'b0;
  logic               ack = 1'b0;
  logic               snooze = 1'b0;
  logic               ringing;
  logic [SLOT_W-1:0]  ring_slot;
  logic               snoozed;
  logic [N_ALARM-1:0] armed;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .N_ALARM      (N_ALARM),
    .SLOT_W       (SLOT_W),
    .RING_SECONDS (60),
    .SNOOZE_MIN   (5),
    .MAX_SNOOZE   (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sec_tick  (sec_tick),
    .now_time  (now_time),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_time  (cfg_time),
    .cfg_en    (cfg_en),
    .ack       (ack),
    .snooze    (snooze),
    .ringing   (ringing),
    .ring_slot (ring_slot),
    .snoozed   (snoozed),
    .armed     (armed)
  );

  function automatic logic [19:0] pack_time(input int secs);
    int s, h, m, sc;
    s  = secs % 86400;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    sb_q.push_back('{tag: tag, val: val});
  endtask

  task automatic observe(input logic [31:0] got);
    exp_t e;
    e.tag = "sb_underflow";
    e.val = 'x;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check_eq(e.tag, got, e.val);
  endtask

  task automatic expect_outs(input string tag, input logic r, input logic s,
                             input logic [N_ALARM-1:0] a);
    expect_val({tag, ".ringing"}, 32'(r));
    expect_val({tag, ".snoozed"}, 32'(s));
    expect_val({tag, ".armed"},   32'(a));
  endtask

  task automatic observe_outs();
    observe(32'(ringing));
    observe(32'(snoozed));
    observe(32'(armed));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_slot(input int slot, input logic [19:0] t, input logic en);
    cfg_slot = SLOT_W'(slot);
    cfg_time = t;
    cfg_en   = en;
    cfg_we   = 1'b1;
    step(1);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic sec_at(input int secs);
    now_time = pack_time(secs);
    step(1);
    pulse_tick();
    step(SPACING);
  endtask

  task automatic press_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic press_snooze();
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rstn = 1'b0;
    step(3);
    expect_outs("reset", 1'b0, 1'b0, 4'b0000);
    expect_val("reset.ring_slot", 32'd0);
    observe_outs();
    observe(32'(ring_slot));
    rstn = 1'b1;
    step(2);

    // Slot 2 at 07:30:00, ring latency t+2+k
    write_slot(2, pack_time(T0730), 1'b1);
    sec_at(T0730 - 2);
    sec_at(T0730 - 1);
    expect_outs("pre0730", 1'b0, 1'b0, 4'b0100);
    observe_outs();
    now_time = pack_time(T0730);
    step(1);
    pulse_tick();
    expect_val("ring_early", 32'd0);
    step(2);
    observe(32'(ringing));
    expect_val("ring_rise", 32'd1);
    expect_val("ring_slot2", 32'd2);
    step(1);
    observe(32'(ringing));
    observe(32'(ring_slot));
    press_ack();
    expect_outs("ack0730", 1'b0, 1'b0, 4'b0100);
    observe_outs();

    // Slots 1 and 3 equal: lowest index wins
    write_slot(1, pack_time(T1200), 1'b1);
    write_slot(3, pack_time(T1200), 1'b1);
    sec_at(T1200);
    expect_outs("dual", 1'b1, 1'b0, 4'b1110);
    expect_val("dual.ring_slot", 32'd1);
    observe_outs();
    observe(32'(ring_slot));
    press_ack();
    step(8);
    expect_val("dual_after_ack", 32'd0);
    observe(32'(ringing));

    // Snooze across midnight
    write_slot(0, pack_time(T2358), 1'b1);
    sec_at(T2358);
    expect_val("r2358", 32'd1);
    expect_val("r2358.ring_slot", 32'd0);
    observe(32'(ringing));
    observe(32'(ring_slot));
    for (int i = 1; i <= 10; i++) sec_at(T2358 + i);
    press_snooze();
    expect_outs("snz1", 1'b0, 1'b1, 4'b1111);
    observe_outs();
    sec_at(189);
    expect_outs("snz1_wait", 1'b0, 1'b1, 4'b1111);
    observe_outs();
    now_time = pack_time(190);
    step(1);
    pulse_tick();
    expect_outs("rering1", 1'b1, 1'b0, 4'b1111);
    expect_val("rering1.ring_slot", 32'd0);
    observe_outs();
    observe(32'(ring_slot));

    // Snoozes 2 and 3 re-ring; the fourth press dismisses
    press_snooze();
    expect_val("snz2", 32'd1);
    observe(32'(snoozed));
    sec_at(490);
    expect_val("rering2", 32'd1);
    observe(32'(ringing));
    press_snooze();
    expect_val("snz3", 32'd1);
    observe(32'(snoozed));
    sec_at(790);
    expect_val("rering3", 32'd1);
    observe(32'(ringing));
    press_snooze();
    expect_outs("snz4", 1'b0, 1'b0, 4'b1111);
    observe_outs();
    sec_at(1090);
    expect_outs("snz4_later", 1'b0, 1'b0, 4'b1111);
    observe_outs();

    // Ring timeout after 60 ticks
    sec_at(T2358);
    for (int i = 1; i <= 59; i++) sec_at(T2358 + i);
    expect_val("tick59", 32'd1);
    observe(32'(ringing));
    now_time = pack_time(T2358 + 60);
    step(1);
    pulse_tick();
    expect_val("tick60", 32'd0);
    observe(32'(ringing));

    // ack and snooze together
    sec_at(T2358);
    ack    = 1'b1;
    snooze = 1'b1;
    step(1);
    ack    = 1'b0;
    snooze = 1'b0;
    expect_outs("ack_snz", 1'b0, 1'b0, 4'b1111);
    observe_outs();

    // Disabling the ringing slot
    sec_at(T2358);
    write_slot(0, pack_time(T2358), 1'b0);
    expect_outs("disable", 1'b0, 1'b0, 4'b1110);
    observe_outs();

    // Asynchronous reset mid-ring
    sec_at(T1200);
    expect_val("pre_rst", 32'd1);
    observe(32'(ringing));
    rstn = 1'b0;
    #1;
    expect_outs("async_rst", 1'b0, 1'b0, 4'b0000);
    expect_val("async_rst.ring_slot", 32'd0);
    observe_outs();
    observe(32'(ring_slot));
    step(2);
    rstn = 1'b1;
    step(2);

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
